param_accum: RTL
================

Name: param_accum

Overview:
- Parameterised frame accumulator and successor to the fixed 8-bit summing dut.
- A programmed length selects N input beats; the block sums them and pushes one result per frame into an output FIFO.
- Adds configurable widths, FIFO depth, signed/unsigned and wrap/saturate modes, pause, sticky overflow and a 32-bit cfg register interface.
- Sits behind the en/rdy method interfaces used across the test wrappers.

Parameters:
- DW, 8, din width in bits.
- SW, 8, sum/dout width in bits; SW >= DW; din is zero- or sign-extended to SW.
- LEN_W, 8, width of len_value and of the remaining-beat counter.
- OUT_DEPTH, 2, dout FIFO entries; >= 1.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- din_value  in  DW  input beat.
- din_en  in  1  beat accepted when din_en && din_rdy.
- din_rdy  out  1  ready for a beat.
- len_value  in  LEN_W  frame length in beats.
- len_en  in  1  length accepted when len_en && len_rdy.
- len_rdy  out  1  ready for a new frame.
- dout_value  out  SW  FIFO head.
- dout_en  in  1  dequeue when dout_en && dout_rdy.
- dout_rdy  out  1  FIFO not empty.
- cfg_address  in  8  register byte address.
- cfg_data_in  in  32  write data.
- cfg_op  in  1  1 = write, 0 = read.
- cfg_en  in  1  cfg request strobe.
- cfg_data_out  out  32  read data, registered.
- cfg_rdy  out  1  always 1.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset: state IDLE; sum = 0; remaining = 0; FIFO empty; all cfg registers = 0. Outputs din_rdy = 0, len_rdy = 1, dout_rdy = 0, dout_value = 0, cfg_data_out = 0, busy = 0.
- Reset mid-frame discards the partial sum and all FIFO contents.
- FSM IDLE:
  - len_rdy = 1.
  - On len accept with len_value != 0: remaining <= len_value, sum <= 0, latch CTRL.sat and CTRL.signed for this frame, go to ACCUM.
  - len_value == 0: no state change, no output.
- FSM ACCUM:
  - din_rdy = !CTRL.pause.
  - Each accepted beat: sum <= f(sum, ext(din)); remaining <= remaining - 1.
  - On the beat where remaining == 1, f(sum, din) is enqueued directly if the FIFO has space or dout is dequeued in the same cycle, then go to IDLE. Otherwise store it in sum and go to HOLD.
  - Latency: dout_rdy rises the cycle after the last beat when the FIFO has space.
- FSM HOLD:
  - din_rdy = 0, len_rdy = 0.
  - Enqueue sum when space exists (including same-cycle dequeue), then go to IDLE.
- Arithmetic, unsigned:
  - Overflow = carry out of SW bits.
  - Wrap mode yields the low SW bits; saturate mode yields 2^SW - 1.
- Arithmetic, signed:
  - Overflow = both operands have the same sign and the result sign differs.
  - Saturate clamps to the max positive or min negative value.
- Any overflow sets sticky STATUS.ovf.
- din_en without din_rdy, len_en without len_rdy, and dout_en without dout_rdy are all ignored.
- FIFO:
  - In-order delivery.
  - Simultaneous enqueue and dequeue when full is legal; occupancy is unchanged.
  - When empty, dout_value holds its last value.
- Register map:
  - 0x00 CTRL (R/W):
    - bit0 sat, bit1 signed, bit2 pause.
    - pause takes effect next cycle; sat and signed apply from the next frame.
  - 0x04 STATUS:
    - bit0 busy (RO); bit1 ovf (W1C); bits[LEN_W+7:8] remaining (RO).
    - If an overflow and a clear occur in the same cycle, the bit ends set.
  - 0x08 RESULTS (RO): 32-bit count of enqueued results, wrapping.
  - 0x0C LAST (RO): last enqueued result, zero-extended.
  - Other addresses read 0; writes to them are ignored.
- Reads: cfg_data_out is valid the cycle after cfg_en with cfg_op = 0 and holds until the next read.

Optional Feature:
- Macro PARAM_ACCUM_MINMAX_EN.
- Defined: adds 0x10 MIN and 0x14 MAX (RO), the minimum and maximum extended din of the most recent completed frame. Comparison follows the frame's signed mode; both registers update on frame completion.
- Undefined: 0x10 and 0x14 read 0, and no comparison logic is built.

Test Plan:
- DW = SW = 8, CTRL = 0, len = 3, din 0x10, 0x20, 0x30 -> dout 0x60 one cycle after the last beat; RESULTS = 1; STATUS.ovf = 0.
- Unsigned wrap, len = 2, din 0xF0, 0x20 -> dout 0x10, STATUS = 0x2. Writing 0x2 to 0x04 -> ovf reads 0.
- Signed saturate:
  - CTRL = 0x3, len = 2, 0x70, 0x20 -> dout 0x7F.
  - Next frame 0x90, 0x90 -> dout 0x80; ovf set.
- OUT_DEPTH = 2, three frames len = 1 (1, 2, 3), dout_en = 0:
  - Third frame sits in HOLD with busy = 1 and len_rdy = 0.
  - Popping one entry -> outputs 1, 2, 3 in order; busy then drops.
- Pause and reset:
  - len = 4, two beats, then CTRL = 0x4 -> din_rdy = 0 and remaining stays 2.
  - Clearing pause -> result correct.
  - RST mid-frame -> len_rdy = 1, dout_rdy = 0, RESULTS = 0.
- With PARAM_ACCUM_MINMAX_EN, signed frame 0x05, 0xFB, 0x10 -> MIN = 0xFB, MAX = 0x10. Without the macro -> both read 0.

Source files
------------

// File: rtl/param_accum.sv
// param_accum: sums a programmed number of input beats per frame and queues one result per frame.
// Define PARAM_ACCUM_MINMAX_EN to add the per-frame MIN (0x10) / MAX (0x14) registers.
module param_accum #(
    parameter int DW        = 8,
    parameter int SW        = 8,
    parameter int LEN_W     = 8,
    parameter int OUT_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DW-1:0]    din_value,
    input  logic             din_en,
    output logic             din_rdy,
    input  logic [LEN_W-1:0] len_value,
    input  logic             len_en,
    output logic             len_rdy,
    output logic [SW-1:0]    dout_value,
    input  logic             dout_en,
    output logic             dout_rdy,
    input  logic [7:0]       cfg_address,
    input  logic [31:0]      cfg_data_in,
    input  logic             cfg_op,
    input  logic             cfg_en,
    output logic [31:0]      cfg_data_out,
    output logic             cfg_rdy,
    output logic             busy
);

    // Handshake: every channel transfers on a cycle where en && rdy are both high;
    // en without rdy is ignored, and no rdy output depends on any en input.

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              frm_sat_q, frm_sat_d;
    logic              frm_sgn_q, frm_sgn_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       results_q, results_d;
    logic [SW-1:0]     last_q, last_d;
    logic [31:0]       cfg_data_out_q, cfg_data_out_d;
    logic [SW-1:0]     mem_q [OUT_DEPTH];
    logic [SW-1:0]     mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SW-1:0]     hold_out_q, hold_out_d;
`ifdef PARAM_ACCUM_MINMAX_EN
    logic [SW-1:0]     min_run_q, min_run_d;
    logic [SW-1:0]     max_run_q, max_run_d;
    logic [SW-1:0]     min_q, min_d;
    logic [SW-1:0]     max_q, max_d;
    logic              first_q, first_d;
    logic [SW-1:0]     new_min, new_max;
`endif

    logic              beat, len_acc, deq, space, enq;
    logic [SW-1:0]     enq_val;
    logic [SW-1:0]     din_ext;
    logic [SW:0]       acc_res;
    logic              ovf_now;
    logic              cfg_wr, cfg_rd;
    logic [31:0]       status_word, rd_data;
    logic              unused_cfg_bits;

    // Returns {overflow, result} for one accumulate step in the frame's mode.
    function automatic logic [SW:0] accum_op(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic sat, input logic sgn);
        logic [SW:0]   full;
        logic [SW-1:0] res;
        logic          ovf;
        full = {1'b0, a} + {1'b0, b};
        res  = full[SW-1:0];
        if (sgn) ovf = (a[SW-1] == b[SW-1]) && (full[SW-1] != a[SW-1]);
        else     ovf = full[SW];
        if (ovf && sat) begin
            if (sgn) begin
                res = a[SW-1] ? '0 : '1;
                res[SW-1] = a[SW-1];
            end else begin
                res = '1;
            end
        end
        return {ovf, res};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_cfg_bits = &{1'b0, cfg_data_in[31:3]};

    assign busy         = (state_q != IDLE);
    assign len_rdy      = (state_q == IDLE);
    assign din_rdy      = (state_q == ACCUM) && !ctrl_q[2];
    assign dout_rdy     = (count_q != '0);
    assign dout_value   = dout_rdy ? mem_q[rd_ptr_q] : hold_out_q;
    assign cfg_data_out = cfg_data_out_q;
    assign cfg_rdy      = 1'b1;

    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        remaining_d    = remaining_q;
        frm_sat_d      = frm_sat_q;
        frm_sgn_d      = frm_sgn_q;
        ctrl_d         = ctrl_q;
        results_d      = results_q;
        last_d         = last_q;
        cfg_data_out_d = cfg_data_out_q;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        hold_out_d     = hold_out_q;
`ifdef PARAM_ACCUM_MINMAX_EN
        min_run_d      = min_run_q;
        max_run_d      = max_run_q;
        min_d          = min_q;
        max_d          = max_q;
        first_d        = first_q;
        new_min        = min_run_q;
        new_max        = max_run_q;
`endif

        beat    = din_en && din_rdy;
        len_acc = len_en && len_rdy && (len_value != '0);
        deq     = dout_en && dout_rdy;
        space   = (count_q != CNT_W'(OUT_DEPTH)) || deq;
        din_ext = frm_sgn_q ? SW'($signed(din_value)) : SW'(din_value);
        acc_res = accum_op(sum_q, din_ext, frm_sat_q, frm_sgn_q);
        enq     = 1'b0;
        enq_val = sum_q;
        ovf_now = 1'b0;
        cfg_wr  = cfg_en && cfg_op;
        cfg_rd  = cfg_en && !cfg_op;

        case (state_q)
            IDLE: begin
                if (len_acc) begin
                    remaining_d = len_value;
                    sum_d       = '0;
                    frm_sat_d   = ctrl_q[0];
                    frm_sgn_d   = ctrl_q[1];
                    state_d     = ACCUM;
`ifdef PARAM_ACCUM_MINMAX_EN
                    first_d     = 1'b1;
`endif
                end
            end
            ACCUM: begin
                if (beat) begin
                    ovf_now     = acc_res[SW];
                    sum_d       = acc_res[SW-1:0];
                    remaining_d = remaining_q - 1'b1;
`ifdef PARAM_ACCUM_MINMAX_EN
                    if (first_q || (frm_sgn_q ? ($signed(din_ext) < $signed(min_run_q))
                                              : (din_ext < min_run_q)))
                        new_min = din_ext;
                    if (first_q || (frm_sgn_q ? ($signed(din_ext) > $signed(max_run_q))
                                              : (din_ext > max_run_q)))
                        new_max = din_ext;
                    min_run_d = new_min;
                    max_run_d = new_max;
                    first_d   = 1'b0;
                    if (remaining_q == LEN_W'(1)) begin
                        min_d = new_min;
                        max_d = new_max;
                    end
`endif
                    // Last beat bypasses HOLD when the FIFO can take it this cycle.
                    if (remaining_q == LEN_W'(1)) begin
                        if (space) begin
                            enq     = 1'b1;
                            enq_val = acc_res[SW-1:0];
                            state_d = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (space) begin
                    enq     = 1'b1;
                    enq_val = sum_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enq) begin
            mem_d[wr_ptr_q] = enq_val;
            wr_ptr_d        = ptr_next(wr_ptr_q);
            results_d       = results_q + 32'd1;
            last_d          = enq_val;
        end
        if (deq) begin
            rd_ptr_d   = ptr_next(rd_ptr_q);
            hold_out_d = mem_q[rd_ptr_q];
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

        // A fresh overflow wins over a same-cycle W1C clear.
        ovf_d = (ovf_q && !(cfg_wr && (cfg_address == 8'h04) && cfg_data_in[1])) || ovf_now;
        if (cfg_wr && (cfg_address == 8'h00))
            ctrl_d = cfg_data_in[2:0];

        status_word              = '0;
        status_word[0]           = busy;
        status_word[1]           = ovf_q;
        status_word[LEN_W+7:8]   = remaining_q;

        case (cfg_address)
            8'h00:   rd_data = 32'(ctrl_q);
            8'h04:   rd_data = status_word;
            8'h08:   rd_data = results_q;
            8'h0C:   rd_data = 32'(last_q);
`ifdef PARAM_ACCUM_MINMAX_EN
            8'h10:   rd_data = 32'(min_q);
            8'h14:   rd_data = 32'(max_q);
`endif
            default: rd_data = '0;
        endcase
        if (cfg_rd)
            cfg_data_out_d = rd_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            sum_q          <= '0;
            remaining_q    <= '0;
            frm_sat_q      <= 1'b0;
            frm_sgn_q      <= 1'b0;
            ctrl_q         <= '0;
            ovf_q          <= 1'b0;
            results_q      <= '0;
            last_q         <= '0;
            cfg_data_out_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            hold_out_q     <= '0;
`ifdef PARAM_ACCUM_MINMAX_EN
            min_run_q      <= '0;
            max_run_q      <= '0;
            min_q          <= '0;
            max_q          <= '0;
            first_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            remaining_q    <= remaining_d;
            frm_sat_q      <= frm_sat_d;
            frm_sgn_q      <= frm_sgn_d;
            ctrl_q         <= ctrl_d;
            ovf_q          <= ovf_d;
            results_q      <= results_d;
            last_q         <= last_d;
            cfg_data_out_q <= cfg_data_out_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            hold_out_q     <= hold_out_d;
`ifdef PARAM_ACCUM_MINMAX_EN
            min_run_q      <= min_run_d;
            max_run_q      <= max_run_d;
            min_q          <= min_d;
            max_q          <= max_d;
            first_q        <= first_d;
`endif
        end
    end

endmodule
